// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: buffers I2S words tagged with their channel; the first ws edge after reset or enable rise is discarded.
// Optional macro I2S_SAMPLE_FIFO_DROP_CNT_EN adds a saturating drop_count output.
module i2s_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       ws,
    input  logic [WIDTH-1:0]           sample_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_right,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
`ifdef I2S_SAMPLE_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            ws_q, primed;
    logic            ws_edge, push, pop, full, wr_en, drop;
    logic [WIDTH:0]  head;

    always_comb begin
        ws_edge   = ws != ws_q;
        push      = ws_edge && enable && primed;
        full      = level == LW'(DEPTH);
        out_valid = level != '0;
        pop       = out_valid && out_ready;
        // a simultaneous pop frees the slot the new word lands in
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
        head      = mem[rd_ptr];
        out_data  = out_valid ? head[WIDTH-1:0] : '0;
        out_right = out_valid ? head[WIDTH] : 1'b0;
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset)
            mem[wr_ptr] <= {ws_q, sample_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ws_q     <= 1'b0;
            primed   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            ws_q   <= ws;
            primed <= enable && (primed || ws_edge);
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)
                level <= level + LW'(1);
            else if (!wr_en && pop)
                level <= level - LW'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end

`ifdef I2S_SAMPLE_FIFO_DROP_CNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// tb_i2s_sample_fifo: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_i2s_sample_fifo;
    localparam int DEPTH = 8;
    localparam int WIDTH = 24;
    localparam int LW = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             ws = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sample_in = '0;
    logic             out_valid, out_right, overflow;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
`ifdef I2S_SAMPLE_FIFO_DROP_CNT_EN
    logic [15:0]      drop_count;
`endif

    i2s_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .enable(enable), .ws(ws),
        .sample_in(sample_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_right(out_right), .level(level),
        .overflow(overflow)
`ifdef I2S_SAMPLE_FIFO_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH:0] q[$];
    logic           m_wsq = 1'b0;
    logic           m_primed = 1'b0;
    logic           m_ovf = 1'b0;
    int             m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [WIDTH:0] h;
        h = q.size() > 0 ? q[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("out_data", 32'(out_data), 32'(h[WIDTH-1:0]));
        chk("out_right", 32'(out_right), 32'(h[WIDTH]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef I2S_SAMPLE_FIFO_DROP_CNT_EN
        chk("drop_count", 32'(drop_count), m_drops > 65535 ? 32'd65535 : 32'(m_drops));
`endif
    endtask

    // one clock: drive at the falling edge, advance the model, check at the next falling edge
    task automatic cyc(input logic r, input logic e, input logic w, input logic [WIDTH-1:0] d, input logic rd);
        logic edg, pop, push;
        reset = r; enable = e; ws = w; sample_in = d; out_ready = rd;
        if (r) begin
            q.delete();
            m_wsq = 1'b0; m_primed = 1'b0; m_ovf = 1'b0; m_drops = 0;
        end else begin
            edg  = w != m_wsq;
            pop  = q.size() > 0 && rd;
            push = edg && e && m_primed;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back({m_wsq, d});
                else begin m_ovf = 1'b1; m_drops++; end
            end
            m_primed = e && (m_primed || edg);
            m_wsq = w;
        end
        @(negedge clock);
        check_all();
    endtask

    task automatic edges(input int n, input int per, input logic e, input logic rd);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < per; j++)
                cyc(1'b0, e, j == 0 ? ~ws : ws, WIDTH'($urandom), rd);
    endtask

    initial begin
        @(negedge clock);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        // ws every 48 clocks, fixed sample: first edge only primes
        for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, 1'((i / 48) % 2), 24'h000055, 1'b1);
        chk("first_push_data_seen", 32'(q.size() == 0), 32'd1);
        // alternating channels with a consumer always ready
        edges(20, 2, 1'b1, 1'b1);
        // stall across 9 edges: one drop, then full-with-pop, then drain
        edges(9, 3, 1'b1, 1'b0);
        chk("full_level", 32'(level), 32'(DEPTH));
        cyc(1'b0, 1'b1, ~ws, WIDTH'($urandom), 1'b1);
        edges(1, 12, 1'b1, 1'b1);
        // enable low for 3 edges, then raised
        edges(3, 3, 1'b0, 1'b0);
        edges(3, 3, 1'b1, 1'b0);
        edges(1, 6, 1'b1, 1'b1);
        // reset with five words stored
        cyc(1'b1, 1'b1, ws, '0, 1'b0);
        for (int i = 0; i < 40 && q.size() < 5; i++) edges(1, 2, 1'b1, 1'b0);
        chk("level_before_reset", 32'(level), 32'd5);
        cyc(1'b1, 1'b1, ws, '0, 1'b0);
        edges(4, 2, 1'b1, 1'b0);
        // random traffic with occasional disables, stalls and resets
        for (int i = 0; i < 5000; i++) begin
            logic rd;
            rd = (i / 200) % 3 == 1 ? ($urandom % 8 == 0) : ($urandom % 3 != 0);
            cyc($urandom % 700 == 0, $urandom % 25 != 0, ($urandom % 3 == 0) ? ~ws : ws,
                WIDTH'($urandom), rd);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
